// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path.
// The nibble type is also used by the downstream hex-to-segment decoder.
package seg_pkg;

  localparam int SEG_MAX_DIGITS = 8;
  localparam int SEG_WORD_W     = 4 * SEG_MAX_DIGITS;

  localparam logic [SEG_MAX_DIGITS-1:0] SEG_AN_OFF = '1;

  typedef logic [3:0]            nibble_t;
  typedef logic [2:0]            digit_idx_t;
  typedef logic [SEG_WORD_W-1:0] seg_word_t;

  // What happens to the active/pending pair on a given cycle.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_PEND,
    UPD_PROMOTE,
    UPD_DIRECT
  } upd_e;

  function automatic nibble_t nibble_at(input seg_word_t value, input digit_idx_t idx);
    seg_word_t shifted;
    shifted = value >> {idx, 2'b00};
    return shifted[3:0];
  endfunction

  // True when every nibble from idx upward is zero.
  function automatic logic upper_is_zero(input seg_word_t value, input digit_idx_t idx);
    seg_word_t shifted;
    shifted = value >> {idx, 2'b00};
    return (shifted == '0);
  endfunction

endpackage

// File: rtl/seg_refresh_tick.sv
// Free-running prescaler: tick is high on the last cycle of every
// REFRESH_DIV-cycle period.
module seg_refresh_tick #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = cnt_q + CNT_ONE;
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed scanner for an N-digit common-anode display with
// frame-synchronous value updates and optional leading-zero blanking.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int N_DIGITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              digit_value,
  output logic [2:0]              digit_sel,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame
);

  localparam int DATA_W = 4 * N_DIGITS;
  localparam digit_idx_t IDX_LAST = digit_idx_t'(N_DIGITS - 1);
  localparam digit_idx_t IDX_ONE  = digit_idx_t'(1);
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);
  localparam logic [N_DIGITS-1:0] AN_OFF = SEG_AN_OFF[N_DIGITS-1:0];

  logic tick;
  logic boundary;
  logic blanked;
  upd_e upd;

  digit_idx_t        idx_q,     idx_d;
  logic [DATA_W-1:0] active_q,  active_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic              pend_v_q,  pend_v_d;
  logic              wrap_q,    wrap_d;

  nibble_t           digit_value_q, digit_value_d;
  digit_idx_t        digit_sel_q,   digit_sel_d;
  logic [N_DIGITS-1:0] an_q,        an_d;
  logic              frame_q,       frame_d;

  seg_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    boundary = tick && (idx_q == IDX_LAST);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IDX_ONE;
    end
    wrap_d = boundary;
  end

  // A load landing on the boundary wins outright and drops any older pending value.
  always_comb begin
    upd = UPD_HOLD;
    if (load && boundary) begin
      upd = UPD_DIRECT;
    end else if (load) begin
      upd = UPD_PEND;
    end else if (boundary && pend_v_q) begin
      upd = UPD_PROMOTE;
    end
  end

  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    case (upd)
      UPD_PEND: begin
        pending_d = data_in;
        pend_v_d  = 1'b1;
      end
      UPD_PROMOTE: begin
        active_d = pending_q;
        pend_v_d = 1'b0;
      end
      UPD_DIRECT: begin
        active_d = data_in;
        pend_v_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Outputs are a registered view of this cycle's scan state.
  always_comb begin
    blanked = blank_lz && (idx_q != '0) && upper_is_zero(seg_word_t'(active_q), idx_q);
    digit_sel_d   = idx_q;
    digit_value_d = nibble_at(seg_word_t'(active_q), idx_q);
    an_d          = ~(AN_ONE << idx_q);
    if (blanked) begin
      an_d = AN_OFF;
    end
    frame_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      pend_v_q      <= 1'b0;
      wrap_q        <= 1'b0;
      digit_value_q <= '0;
      digit_sel_q   <= '0;
      an_q          <= AN_OFF;
      frame_q       <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pend_v_q      <= pend_v_d;
      wrap_q        <= wrap_d;
      digit_value_q <= digit_value_d;
      digit_sel_q   <= digit_sel_d;
      an_q          <= an_d;
      frame_q       <= frame_d;
    end
  end

  assign digit_value = digit_value_q;
  assign digit_sel   = digit_sel_q;
  assign an          = an_q;
  assign frame       = frame_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan with REFRESH_DIV=4, N_DIGITS=8.
// A cycle-position reference model checks every output on every cycle.
module tb_seg_display_scan;

   localparam int DIV       = 4;
   localparam int ND        = 8;
   localparam int FRAME_LEN = DIV * ND;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic        load;
   logic        blank_lz;
   logic [3:0]  digit_value;
   logic [2:0]  digit_sel;
   logic [7:0]  an;
   logic        frame;

   int checks = 0;
   int errors = 0;

   // Reference model: position in the scan since reset plus the value pair
   int unsigned mPos;
   logic [31:0] mActive;
   logic [31:0] mPending;
   bit          mPendV;
   logic [7:0]  expAn;
   logic [3:0]  expVal;
   logic [2:0]  expSel;
   logic        expFrame;

   typedef struct {
      logic [31:0] data;
      logic        blz;
      int          digit;
      logic [7:0]  expAnT;
      logic [3:0]  expValT;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   seg_display_scan #(
      .REFRESH_DIV (DIV),
      .N_DIGITS    (ND)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .load        (load),
      .blank_lz    (blank_lz),
      .digit_value (digit_value),
      .digit_sel   (digit_sel),
      .an          (an),
      .frame       (frame)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs come from the scan position: digit = (pos/DIV) mod ND
   task automatic modelEdge(input logic ld, input logic [31:0] d, input logic blz, input logic r);
      int          digit;
      logic [31:0] upper;
      bit          blank;
      bit          boundary;
      if (r) begin
         mPos = 0; mActive = '0; mPending = '0; mPendV = 0;
         expAn = 8'hFF; expVal = '0; expSel = '0; expFrame = 1'b0;
      end else begin
         digit    = (mPos / DIV) % ND;
         upper    = mActive >> (4 * digit);
         blank    = blz && (digit > 0) && (upper == 0);
         expSel   = digit[2:0];
         expVal   = upper[3:0];
         expAn    = blank ? 8'hFF : ~(8'h01 << digit);
         expFrame = (mPos > 0) && (mPos % FRAME_LEN == 0);
         boundary = (mPos % FRAME_LEN == FRAME_LEN - 1);
         if (ld && boundary) begin
            mActive = d; mPendV = 0;
         end else if (ld) begin
            mPending = d; mPendV = 1;
         end else if (boundary && mPendV) begin
            mActive = mPending; mPendV = 0;
         end
         mPos++;
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic blz, input logic r);
      @(negedge clk);
      load = ld; data_in = d; blank_lz = blz; rst = r;
      @(posedge clk);
      modelEdge(ld, d, blz, r);
      #1;
      checkOutput("model_an", 32'(an), 32'(expAn));
      checkOutput("model_value", 32'(digit_value), 32'(expVal));
      checkOutput("model_sel", 32'(digit_sel), 32'(expSel));
      checkOutput("model_frame", 32'(frame), 32'(expFrame));
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   initial begin
      int frameCount;
      logic randBlz;
      logic [31:0] rd;

      rst = 1'b1; load = 1'b0; data_in = '0; blank_lz = 1'b0;

      vecs[0]  = '{32'h1234ABCD, 1'b0, 0, 8'hFE, 4'hD};
      vecs[1]  = '{32'h1234ABCD, 1'b0, 3, 8'hF7, 4'hA};
      vecs[2]  = '{32'h1234ABCD, 1'b0, 7, 8'h7F, 4'h1};
      vecs[3]  = '{32'h1234ABCD, 1'b1, 0, 8'hFE, 4'hD};
      vecs[4]  = '{32'h00000F00, 1'b1, 0, 8'hFE, 4'h0};
      vecs[5]  = '{32'h00000F00, 1'b1, 1, 8'hFD, 4'h0};
      vecs[6]  = '{32'h00000F00, 1'b1, 2, 8'hFB, 4'hF};
      vecs[7]  = '{32'h00000F00, 1'b1, 3, 8'hFF, 4'h0};
      vecs[8]  = '{32'h00000F00, 1'b1, 7, 8'hFF, 4'h0};
      vecs[9]  = '{32'h00000000, 1'b1, 0, 8'hFE, 4'h0};
      vecs[10] = '{32'h00000000, 1'b1, 1, 8'hFF, 4'h0};
      vecs[11] = '{32'h00000F00, 1'b0, 5, 8'hDF, 4'h0};
      vecs[12] = '{32'h80000000, 1'b1, 4, 8'hEF, 4'h0};

      // Reset release: dark during reset, then digit 0, frames every 32 cycles
      doReset();
      checkOutput("reset_an", 32'(an), 32'hFF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("release_an", 32'(an), 32'hFE);
      checkOutput("release_value", 32'(digit_value), 32'h0);
      frameCount = 0;
      for (int c = 0; c < 69; c++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         if (frame === 1'b1) frameCount++;
      end
      checkOutput("frame_count", 32'(frameCount), 32'd2);

      // Load at cycle 5 holds 0 until the boundary, then shows the new value
      doReset();
      for (int c = 0; c < 5; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h1234ABCD, 1'b0, 1'b0);
      for (int c = 0; c < 60; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      // Table: load at position 0, probe the chosen digit in the next frame
      for (int v = 0; v < 13; v++) begin
         doReset();
         applyStimulus(1'b1, vecs[v].data, vecs[v].blz, 1'b0);
         for (int c = 0; c < FRAME_LEN + 4 * vecs[v].digit + 1; c++)
            applyStimulus(1'b0, 32'h0, vecs[v].blz, 1'b0);
         checkOutput("table_an", 32'(an), 32'(vecs[v].expAnT));
         checkOutput("table_value", 32'(digit_value), 32'(vecs[v].expValT));
         checkOutput("table_sel", 32'(digit_sel), 32'(vecs[v].digit));
      end

      // Two loads in one frame: the last one wins
      doReset();
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b0);
      for (int c = 0; c < FRAME_LEN && mPos < FRAME_LEN; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      for (int c = 0; c < FRAME_LEN; c++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         checkOutput("last_load_wins", 32'(digit_value), 32'h2);
      end

      // Load on the boundary cycle overrides an older pending value
      doReset();
      for (int c = 0; c < 10; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h33333333, 1'b0, 1'b0);
      for (int c = 0; c < FRAME_LEN && mPos < FRAME_LEN - 1; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h55555555, 1'b0, 1'b0);
      for (int c = 0; c < FRAME_LEN; c++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         checkOutput("boundary_load", 32'(digit_value), 32'h5);
      end

      // Reset while digit 5 is lit with a pending load
      doReset();
      for (int c = 0; c < 20; c++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h77777777, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("digit5_an", 32'(an), 32'hDF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("midreset_an", 32'(an), 32'hFF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("restart_an", 32'(an), 32'hFE);
      checkOutput("restart_value", 32'(digit_value), 32'h0);
      for (int c = 0; c < 40; c++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         checkOutput("pending_dropped", 32'(digit_value), 32'h0);
      end

      // Randomised traffic against the model
      doReset();
      randBlz = 1'b0;
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 99) == 0) randBlz = ~randBlz;
         rd = $urandom >> (4 * $urandom_range(0, 7));
         applyStimulus(($urandom_range(0, 15) == 0), rd, randBlz, ($urandom_range(0, 499) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
